input_ctrl: RTL and testbench

Write-side packet controller for one ingress port of the multi-port shared cache. It accepts a packet word stream and obtains 64-byte blocks from the free-block allocator. It writes the packet into the shared memory block by block, and pushes each filled block address, tagged with destination port, first/last flags and length, into the destination port's block queue. That queue is later drained by the read-side controller.

---
 rtl/input_ctrl.sv | 174 +++++++++++++++++
 tb/tb_input_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_ctrl.sv
// input_ctrl: ingress write-side controller; splits a packet stream into 64-byte blocks and queues each block for its port.
// Ports: i_data/i_vld/i_sop/i_eop/o_rdy stream in, o_alloc_req/i_alloc_* block grant, o_wr_* memory write, o_enq_*/i_enq_rdy block queue push, o_len_err/o_err pulses.
// Latency: write one cycle after accept. Backpressure: o_rdy drops while waiting for a grant (ALLOC) or an enqueue accept (ENQ).
module input_ctrl #(
    parameter int PORTNUM        = 16,
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH      = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_BLK  = 16
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic [DATA_WIDTH-1:0]                            i_data,
    input  logic                                             i_vld,
    input  logic                                             i_sop,
    input  logic                                             i_eop,
    output logic                                             o_rdy,
    output logic                                             o_alloc_req,
    input  logic [BLK_ADDR_WIDTH-1:0]                        i_alloc_addr,
    input  logic                                             i_alloc_vld,
    output logic                                             o_wr_en,
    output logic [BLK_ADDR_WIDTH+$clog2(WORDS_PER_BLK)-1:0]  o_wr_addr,
    output logic [DATA_WIDTH-1:0]                            o_wr_data,
    output logic                                             o_enq_vld,
    input  logic                                             i_enq_rdy,
    output logic [$clog2(PORTNUM)-1:0]                       o_enq_port,
    output logic [BLK_ADDR_WIDTH-1:0]                        o_enq_blk_addr,
    output logic                                             o_enq_first,
    output logic                                             o_enq_last,
    output logic [LEN_WIDTH-1:0]                             o_enq_len,
    output logic                                             o_len_err,
    output logic                                             o_err
);

    localparam int PW = $clog2(PORTNUM);
    localparam int IW = $clog2(WORDS_PER_BLK);
    localparam int CW = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_WRITE = 2'd2,
        S_ENQ   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BLK_ADDR_WIDTH-1:0] r_blk;
    logic [IW-1:0]             r_idx;
    logic [CW-1:0]             r_cnt;       // words accepted in this packet, saturating
    logic [PW-1:0]             r_port;
    logic [LEN_WIDTH-1:0]      r_len;
    logic                      r_first_blk; // next enqueue is the packet's first

    logic                      w_hdr_beat;
    logic [PW-1:0]             w_port;
    logic [LEN_WIDTH-1:0]      w_len;
    logic [CW-1:0]             w_exp_words;
    logic [CW-1:0]             w_cnt_inc;
    logic                      w_blk_full;

    // The header beat's fields are used directly so a one-word packet
    // (sop and eop together) enqueues with the right port and length.
    assign w_hdr_beat  = (r_cnt == '0);
    assign w_port      = w_hdr_beat ? i_data[LEN_WIDTH+PW-1:LEN_WIDTH] : r_port;
    assign w_len       = w_hdr_beat ? i_data[LEN_WIDTH-1:0] : r_len;
    assign w_exp_words = ({1'b0, w_len} + CW'(7)) >> 2;
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    assign w_blk_full  = (r_idx == IW'(WORDS_PER_BLK - 1));

    always_comb begin
        w_state_nxt = r_state;
        o_rdy       = 1'b0;
        o_alloc_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Non-sop beats are swallowed; a sop beat is left on the bus
                // until a block is available.
                o_rdy = i_vld & ~i_sop;
                if (i_vld & i_sop) w_state_nxt = S_ALLOC;
            end
            S_ALLOC: begin
                o_alloc_req = 1'b1;
                if (i_alloc_vld) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                o_rdy = 1'b1;
                if (i_vld & (i_eop | w_blk_full)) w_state_nxt = S_ENQ;
            end
            S_ENQ: begin
                if (i_enq_rdy) w_state_nxt = o_enq_last ? S_IDLE : S_ALLOC;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_blk          <= '0;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_port         <= '0;
            r_len          <= '0;
            r_first_blk    <= 1'b0;
            o_wr_en        <= 1'b0;
            o_wr_addr      <= '0;
            o_wr_data      <= '0;
            o_enq_vld      <= 1'b0;
            o_enq_port     <= '0;
            o_enq_blk_addr <= '0;
            o_enq_first    <= 1'b0;
            o_enq_last     <= 1'b0;
            o_enq_len      <= '0;
            o_len_err      <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            o_wr_en   <= 1'b0;
            o_len_err <= 1'b0;
            o_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt       <= '0;
                    r_first_blk <= 1'b1;
                    if (i_vld & ~i_sop) o_err <= 1'b1;
                end
                S_ALLOC: begin
                    if (i_alloc_vld) begin
                        r_blk <= i_alloc_addr;
                        r_idx <= '0;
                    end
                end
                S_WRITE: begin
                    if (i_vld) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= {r_blk, r_idx};
                        o_wr_data <= i_data;
                        r_idx     <= r_idx + IW'(1);
                        r_cnt     <= w_cnt_inc;
                        if (w_hdr_beat) begin
                            r_port <= w_port;
                            r_len  <= w_len;
                        end else if (i_sop) begin
                            o_err <= 1'b1;
                        end
                        if (i_eop | w_blk_full) begin
                            o_enq_vld      <= 1'b1;
                            o_enq_port     <= w_port;
                            o_enq_blk_addr <= r_blk;
                            o_enq_first    <= r_first_blk;
                            o_enq_last     <= i_eop;
                            o_enq_len      <= r_first_blk ? w_len : '0;
                            if (i_eop) o_len_err <= (w_cnt_inc != w_exp_words);
                        end
                    end
                end
                S_ENQ: begin
                    if (i_enq_rdy) begin
                        o_enq_vld      <= 1'b0;
                        o_enq_port     <= '0;
                        o_enq_blk_addr <= '0;
                        o_enq_first    <= 1'b0;
                        o_enq_last     <= 1'b0;
                        o_enq_len      <= '0;
                        r_first_blk    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_input_ctrl.sv
// tb_input_ctrl: directed and randomized packets against a block-level reference model.
// Latency: checks run per packet once all its enqueues are seen.
// Backpressure: bench stalls grants and enqueue accepts to exercise o_rdy drop.
`define CHK(TAG, OBS, EXP) \
    begin \
        total++; \
        assert ((OBS) === (EXP)) else begin \
            bad++; \
            $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_input_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_data = '0;
    logic        i_vld = 1'b0;
    logic        i_sop = 1'b0;
    logic        i_eop = 1'b0;
    logic        o_rdy;
    logic        o_alloc_req;
    logic [9:0]  i_alloc_addr;
    logic        i_alloc_vld;
    logic        o_wr_en;
    logic [13:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_enq_vld;
    logic        i_enq_rdy;
    logic [3:0]  o_enq_port;
    logic [9:0]  o_enq_blk_addr;
    logic        o_enq_first;
    logic        o_enq_last;
    logic [9:0]  o_enq_len;
    logic        o_len_err;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    input_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_vld(i_vld),
        .i_sop(i_sop), .i_eop(i_eop), .o_rdy(o_rdy), .o_alloc_req(o_alloc_req),
        .i_alloc_addr(i_alloc_addr), .i_alloc_vld(i_alloc_vld), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_enq_vld(o_enq_vld),
        .i_enq_rdy(i_enq_rdy), .o_enq_port(o_enq_port), .o_enq_blk_addr(o_enq_blk_addr),
        .o_enq_first(o_enq_first), .o_enq_last(o_enq_last), .o_enq_len(o_enq_len),
        .o_len_err(o_len_err), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // shared state between stimulus, responders and monitor
    logic [9:0]  alloc_q[$];
    logic [9:0]  plan_blks[$];
    int          gnt_delay = 0;
    int          enq_mode  = 0;
    logic [45:0] wr_q[$];
    logic [25:0] enq_q[$];
    int          err_cnt = 0;
    int          len_err_cnt = 0;
    int          req_run = 0;
    int          req_run_max = 0;
    int          enq_run = 0;
    int          enq_run_last = 0;

    // free-block allocator: hands out queued addresses after gnt_delay request cycles
    initial begin
        int req_cnt;
        req_cnt      = 0;
        i_alloc_vld  = 1'b0;
        i_alloc_addr = '0;
        forever begin
            @(posedge i_clk); #1;
            i_alloc_vld = 1'b0;
            if (o_alloc_req) begin
                if (req_cnt >= gnt_delay && alloc_q.size() > 0) begin
                    i_alloc_vld  = 1'b1;
                    i_alloc_addr = alloc_q.pop_front();
                end
                req_cnt++;
            end else begin
                req_cnt = 0;
            end
        end
    end

    // block queue: always ready, random, or hold off the first 3 cycles of each push
    initial begin
        int hold;
        hold      = 0;
        i_enq_rdy = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if (!o_enq_vld) hold = 0;
            case (enq_mode)
                0:       i_enq_rdy = 1'b1;
                1:       i_enq_rdy = 1'($urandom_range(0, 1));
                default: i_enq_rdy = (hold >= 3);
            endcase
            if (o_enq_vld) hold++;
        end
    end

    // monitor: collects writes/enqueues/pulses and checks per-cycle handshake rules
    initial begin
        logic [25:0] cur_enq;
        logic [25:0] prev_enq;
        logic        enq_pend;
        logic        excl;
        prev_enq = '0;
        enq_pend = 1'b0;
        forever begin
            @(negedge i_clk);
            cur_enq = {o_enq_port, o_enq_blk_addr, o_enq_first, o_enq_last, o_enq_len};
            if (o_wr_en) wr_q.push_back({o_wr_addr, o_wr_data});
            if (o_err) err_cnt++;
            if (o_len_err) len_err_cnt++;
            if (o_alloc_req) req_run++; else req_run = 0;
            if (req_run > req_run_max) req_run_max = req_run;
            if (!i_rst) begin
                excl = o_alloc_req & (o_rdy | o_wr_en);
                `CHK("alloc_excl", excl, 1'b0)
                if (enq_pend) begin
                    `CHK("enq_held", o_enq_vld, 1'b1)
                    `CHK("enq_stable", cur_enq, prev_enq)
                end
                if (o_enq_vld) `CHK("enq_no_rdy", o_rdy, 1'b0)
            end
            if (o_enq_vld) begin
                enq_run++;
                if (i_enq_rdy) begin
                    enq_q.push_back(cur_enq);
                    enq_run_last = enq_run;
                    enq_run = 0;
                end
            end
            enq_pend = o_enq_vld & ~i_enq_rdy & ~i_rst;
            prev_enq = cur_enq;
        end
    end

    // called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_beat(input logic [31:0] d, input logic s, input logic e);
        int c;
        i_data = d; i_sop = s; i_eop = e; i_vld = 1'b1;
        c = 0;
        @(negedge i_clk);
        while (!o_rdy && c < 300) begin
            @(negedge i_clk);
            c++;
        end
        `CHK("beat_accept_timeout", o_rdy, 1'b1)
        @(posedge i_clk); #1;
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    endtask

    // Builds a packet, predicts writes/enqueues/errors from block arithmetic, sends it, compares.
    task automatic run_packet(input int n, input logic [9:0] len, input logic [3:0] port,
                              input int sop_err_pos, input int stray, input int gap_max);
        logic [31:0] words[$];
        logic [9:0]  blks[$];
        logic [45:0] exp_wr[$];
        logic [25:0] exp_enq[$];
        logic [31:0] r;
        logic [9:0]  b_addr;
        logic [3:0]  widx;
        logic [9:0]  elen;
        logic        f, l;
        int nb, exp_err, exp_len_err, c;
        nb = (n + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            b_addr = (plan_blks.size() > 0) ? plan_blks.pop_front() : 10'($urandom);
            blks.push_back(b_addr);
            alloc_q.push_back(b_addr);
        end
        for (int j = 0; j < n; j++) begin
            r = $urandom;
            if (j == 0) words.push_back({r[17:0], port, len});
            else        words.push_back(r);
            widx = 4'(j % 16);
            exp_wr.push_back({blks[j / 16], widx, words[j]});
        end
        for (int b = 0; b < nb; b++) begin
            f = (b == 0);
            l = (b == nb - 1);
            elen = f ? len : 10'd0;
            exp_enq.push_back({port, blks[b], f, l, elen});
        end
        exp_err     = stray + ((sop_err_pos > 0 && sop_err_pos < n) ? 1 : 0);
        exp_len_err = (n != (int'(len) + 7) / 4) ? 1 : 0;

        wr_q.delete(); enq_q.delete();
        err_cnt = 0; len_err_cnt = 0; req_run_max = 0;

        if (stray != 0) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
        for (int j = 0; j < n; j++) begin
            send_beat(words[j], (j == 0) || (j == sop_err_pos), j == n - 1);
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge i_clk); #1;
            end
        end
        c = 0;
        while (enq_q.size() < nb && c < 400) begin
            @(negedge i_clk);
            c++;
        end
        repeat (2) @(negedge i_clk);

        `CHK("wr_count", wr_q.size(), exp_wr.size())
        for (int i = 0; i < n && i < wr_q.size(); i++) `CHK("wr_beat", wr_q[i], exp_wr[i])
        `CHK("enq_count", enq_q.size(), exp_enq.size())
        for (int i = 0; i < nb && i < enq_q.size(); i++) `CHK("enq_entry", enq_q[i], exp_enq[i])
        `CHK("err_pulses", err_cnt, exp_err)
        `CHK("len_err_pulses", len_err_cnt, exp_len_err)
        @(posedge i_clk); #1;
    endtask

    initial begin
        logic [77:0] outs;
        logic [13:0] a7;
        logic [9:0]  rl;
        int rn, rsop;

        // reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        outs = {o_rdy, o_alloc_req, o_wr_en, o_wr_addr, o_wr_data, o_enq_vld, o_enq_port,
                o_enq_blk_addr, o_enq_first, o_enq_last, o_enq_len, o_len_err, o_err};
        `CHK("reset_outputs", outs, 78'd0)
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // 16-word packet fills exactly one block
        plan_blks.push_back(10'h010);
        run_packet(16, 10'd60, 4'd5, -1, 0, 0);

        // 17 words spill one word into a second block
        plan_blks.push_back(10'h020); plan_blks.push_back(10'h021);
        run_packet(17, 10'd61, 4'd7, -1, 0, 0);

        // slow allocator: grant 5 cycles after the request rises
        gnt_delay = 5;
        run_packet(20, 10'd75, 4'd3, -1, 0, 0);
        `CHK("alloc_req_run", req_run_max, 6)
        gnt_delay = 0;

        // block queue holds off each push for 3 cycles
        enq_mode = 2;
        run_packet(17, 10'd61, 4'd1, -1, 0, 0);
        `CHK("enq_vld_cycles", enq_run_last, 4)
        enq_mode = 0;

        // header says 3 words but eop on the 5th; stray beat first in IDLE
        run_packet(5, 10'd8, 4'd2, -1, 1, 0);

        // reset in the middle of a packet after 7 words
        wr_q.delete(); enq_q.delete();
        alloc_q.push_back(10'h0AB);
        send_beat({18'h0, 4'd3, 10'd100}, 1'b1, 1'b0);
        for (int j = 1; j < 7; j++) send_beat($urandom, 1'b0, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        outs = {o_rdy, o_alloc_req, o_wr_en, o_wr_addr, o_wr_data, o_enq_vld, o_enq_port,
                o_enq_blk_addr, o_enq_first, o_enq_last, o_enq_len, o_len_err, o_err};
        `CHK("midpkt_reset_outputs", outs, 78'd0)
        `CHK("midpkt_writes", wr_q.size(), 7)
        a7 = (wr_q.size() == 7) ? wr_q[6][45:32] : 14'h0;
        `CHK("midpkt_last_addr", a7, 14'h0AB6)
        `CHK("midpkt_no_enq", enq_q.size(), 0)
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        alloc_q.delete();
        run_packet(1, 10'd0, 4'd9, -1, 0, 0);

        // randomized packets with random gaps, grant delays, queue stalls and errors
        enq_mode = 1;
        for (int k = 0; k < 25; k++) begin
            rn = $urandom_range(1, 40);
            if ($urandom_range(0, 3) == 0) rl = 10'($urandom_range(0, 1023));
            else if (rn == 1)              rl = 10'd0;
            else                           rl = 10'(4 * rn - 7 + $urandom_range(0, 3));
            rsop = (rn > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, rn - 1) : -1;
            gnt_delay = $urandom_range(0, 3);
            run_packet(rn, rl, 4'($urandom), rsop, ($urandom_range(0, 3) == 0) ? 1 : 0,
                       $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
